// File: rtl/spi_reg_ctrl.sv
// Frame-level controller behind a byte-wide SPI slave: a command byte selects
// read/write and a start address, then data streams through an auto-incrementing pointer.

module spi_reg_cell #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] q
);
  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we) q_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module spi_reg_ctrl #(
  parameter int         NREGS   = 16,
  parameter logic [7:0] ID_BYTE = 8'hA5,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_ss_q,
  input  logic               spi_done,
  input  logic [7:0]         spi_dout,
  output logic [7:0]         spi_din,
  output logic [8*NREGS-1:0] regs,
  output logic               wr_pulse,
  output logic [6:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy,
  output logic               oor_err
);
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  localparam logic [7:0] NREGS_B = 8'(NREGS);

  state_t                  state_q, state_d;
  logic [6:0]              addr_ptr_q, addr_ptr_d;
  logic [7:0]              spi_din_q, spi_din_d;
  logic                    wr_pulse_q, wr_pulse_d;
  logic [6:0]              wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic                    oor_err_q, oor_err_d;
  logic                    reg_we;
  logic [NREGS-1:0][7:0]   reg_q;
  logic [6:0]              rd_addr;
  logic [7:0]              rd_data;
  logic                    rd_ok, ptr_ok;

  // One read port: the command byte's address in CMD, the pointer otherwise.
  always_comb begin
    rd_addr = (state_q == CMD) ? spi_dout[6:0] : addr_ptr_q;
    rd_ok   = ({1'b0, rd_addr} < NREGS_B);
    ptr_ok  = ({1'b0, addr_ptr_q} < NREGS_B);
    rd_data = 8'h00;
    for (int k = 0; k < NREGS; k++)
      if (rd_addr == 7'(k)) rd_data = reg_q[k];
  end

  always_comb begin
    state_d    = state_q;
    addr_ptr_d = addr_ptr_q;
    spi_din_d  = spi_din_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    oor_err_d  = oor_err_q;
    reg_we     = 1'b0;
    case (state_q)
      IDLE: begin
        spi_din_d = ID_BYTE;
        if (!spi_ss_q) state_d = CMD;
      end
      CMD: begin
        if (spi_done) begin
          if (spi_dout[7]) begin
            addr_ptr_d = spi_dout[6:0];
            state_d    = WRITE;
          end else begin
            addr_ptr_d = spi_dout[6:0] + 7'd1;
            spi_din_d  = rd_data;
            if (!rd_ok) oor_err_d = 1'b1;
            state_d    = READ;
          end
        end
      end
      WRITE: begin
        if (spi_done) begin
          if (ptr_ok) begin
            reg_we     = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = addr_ptr_q;
            wr_data_d  = spi_dout;
          end else begin
            oor_err_d  = 1'b1;
          end
          addr_ptr_d = addr_ptr_q + 7'd1;
        end
      end
      READ: begin
        if (spi_done) begin
          spi_din_d  = rd_data;
          if (!rd_ok) oor_err_d = 1'b1;
          addr_ptr_d = addr_ptr_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Deselect wins over everything above except the byte commit itself.
    if (state_q != IDLE && spi_ss_q) begin
      state_d   = IDLE;
      spi_din_d = ID_BYTE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_ptr_q <= 7'd0;
      spi_din_q  <= ID_BYTE;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 8'h00;
      oor_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_ptr_q <= addr_ptr_d;
      spi_din_q  <= spi_din_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      oor_err_q  <= oor_err_d;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_reg
    spi_reg_cell #(.RST_VAL(RST_VAL)) u_cell (
      .clk   (clk),
      .rst   (rst),
      .we    (reg_we && (addr_ptr_q == 7'(k))),
      .wdata (spi_dout),
      .q     (reg_q[k])
    );
  end

  assign regs     = reg_q;
  assign spi_din  = spi_din_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != IDLE);
  assign oor_err  = oor_err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl; drives the SPI slave handshake directly and
// records the byte the slave would load for MISO at frame start and at each done.
module tb_spi_reg_ctrl;
  localparam int NREGS = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               spi_ss_q;
  logic               spi_done;
  logic [7:0]         spi_dout;
  logic [7:0]         spi_din;
  logic [8*NREGS-1:0] regs;
  logic               wr_pulse;
  logic [6:0]         wr_addr;
  logic [7:0]         wr_data;
  logic               busy;
  logic               oor_err;

  spi_reg_ctrl #(.NREGS(NREGS), .ID_BYTE(8'hA5), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .spi_ss_q(spi_ss_q), .spi_done(spi_done),
    .spi_dout(spi_dout), .spi_din(spi_din), .regs(regs), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          npulse = 0;
  int          ndouble = 0;
  int          base;
  logic        prev_pulse = 1'b0;
  logic [14:0] pulses[$];
  logic [7:0]  miso[$];

  always @(negedge clk) begin
    if (wr_pulse) begin
      npulse++;
      pulses.push_back({wr_addr, wr_data});
    end
    if (wr_pulse && prev_pulse) ndouble++;
    prev_pulse = wr_pulse;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg8(input int k);
    return regs[8*k +: 8];
  endfunction

  task automatic chk_frame(input string tag, input logic [31:0] exp, input int n);
    chk({tag, " len"}, 128'(miso.size() >= n), 128'(1));
    for (int i = 0; i < n; i++)
      if (i < miso.size())
        chk($sformatf("%s byte%0d", tag, i), 128'(miso[i]), 128'(exp[31-8*i -: 8]));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_ss_q = 1'b0;
    miso.delete();
    miso.push_back(spi_din);
  endtask

  task automatic ss_high();
    @(negedge clk);
    spi_ss_q = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    spi_dout = b;
    spi_done = 1'b1;
    miso.push_back(spi_din);
    @(negedge clk);
    spi_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; spi_ss_q = 1'b1; spi_done = 1'b0; spi_dout = 8'h00;

    // 1 reset
    do_reset();
    chk("rst spi_din", spi_din, 8'hA5);
    chk("rst regs", regs, '0);
    chk("rst busy", busy, 0);
    chk("rst oor_err", oor_err, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);

    // 2 write burst
    base = npulse; pulses.delete();
    ss_low(); send(8'h83); send(8'h11); send(8'h22);
    chk("t2 busy in frame", busy, 1);
    ss_high();
    chk("t2 busy after", busy, 0);
    chk("t2 reg3", reg8(3), 8'h11);
    chk("t2 reg4", reg8(4), 8'h22);
    chk("t2 npulse", npulse - base, 2);
    if (pulses.size() >= 2) begin
      chk("t2 pulse0", pulses[0], {7'd3, 8'h11});
      chk("t2 pulse1", pulses[1], {7'd4, 8'h22});
    end
    chk_frame("t2 miso", 32'hA5A5A5_00, 3);

    // 3 read burst
    base = npulse;
    ss_low(); send(8'h03); send(8'h00); send(8'h00); send(8'h00); ss_high();
    chk_frame("t3 miso", 32'hA5A51122, 4);
    chk("t3 npulse", npulse - base, 0);

    // 4 abort with a partial byte
    ss_low(); send(8'h85);
    repeat (4) @(negedge clk);
    ss_high();
    chk("t4 reg5", reg8(5), 8'h00);
    chk("t4 busy", busy, 0);
    chk("t4 spi_din", spi_din, 8'hA5);
    ss_low(); send(8'h05); send(8'h00); send(8'h00); ss_high();
    chk_frame("t4 miso", 32'hA5A500_00, 3);
    chk("t4 oor clean", oor_err, 0);

    // 5 wrap and unmapped
    base = npulse; pulses.delete();
    ss_low(); send(8'hFF); send(8'hAA); send(8'hBB); ss_high();
    chk("t5 npulse", npulse - base, 1);
    if (pulses.size() >= 1) chk("t5 pulse0", pulses[0], {7'd0, 8'hBB});
    chk("t5 oor_err", oor_err, 1);
    chk("t5 reg0", reg8(0), 8'hBB);
    ss_low(); send(8'h7F); send(8'h00); send(8'h00); send(8'h00); ss_high();
    chk_frame("t5 miso", 32'hA5A500BB, 4);

    // 6 reset mid write frame
    ss_low(); send(8'h81); send(8'h44);
    chk("t6 reg1 pre", reg8(1), 8'h44);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t6 reg1 rst", reg8(1), 8'h00);
    chk("t6 busy rst", busy, 0);
    chk("t6 oor rst", oor_err, 0);
    @(negedge clk); rst = 1'b0;
    base = npulse;
    send(8'h02); send(8'h03);
    chk("t6 no write", npulse - base, 0);
    chk("t6 reg1 held", reg8(1), 8'h00);
    ss_high();
    base = npulse;
    ss_low(); send(8'h81); send(8'h44); ss_high();
    chk("t6 reg1 new frame", reg8(1), 8'h44);
    chk("t6 npulse", npulse - base, 1);

    // done and deselect in the same cycle: byte commits, frame ends
    ss_low(); send(8'h86);
    @(negedge clk); spi_dout = 8'h77; spi_done = 1'b1; spi_ss_q = 1'b1;
    @(negedge clk); spi_done = 1'b0;
    @(negedge clk);
    chk("t7 reg6", reg8(6), 8'h77);
    chk("t7 busy", busy, 0);
    chk("t7 spi_din", spi_din, 8'hA5);

    // done while idle is ignored
    base = npulse;
    send(8'h99);
    chk("t8 idle npulse", npulse - base, 0);
    chk("t8 idle busy", busy, 0);

    chk("wr_pulse double", ndouble, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
